// File: rtl/qpn_alloc_ctrl.sv
// Queue-pair number allocator: pops free QPNs on open, validates and returns them on close.
// Optional error statistics counters enabled by defining QPN_ALLOC_STATS_EN.
module qpn_alloc_ctrl #(
    parameter int MAX_QUEUE_PAIRS = 4,
    localparam int CW = $clog2(MAX_QUEUE_PAIRS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_open_req_valid,
    output logic          s_open_req_ready,
    output logic          m_open_rsp_valid,
    input  logic          m_open_rsp_ready,
    output logic [23:0]   m_open_rsp_qpn,
    output logic          m_open_rsp_error,
    input  logic          s_close_req_valid,
    output logic          s_close_req_ready,
    input  logic [23:0]   s_close_req_qpn,
    output logic          m_close_rsp_valid,
    input  logic          m_close_rsp_ready,
    output logic          m_close_rsp_error,
    input  logic          s_free_qpn_valid,
    output logic          s_free_qpn_ready,
    input  logic [23:0]   s_free_qpn,
    output logic          m_free_qpn_valid,
    input  logic          m_free_qpn_ready,
    output logic [23:0]   m_free_qpn,
    output logic [CW-1:0] active_qp_count
`ifdef QPN_ALLOC_STATS_EN
    ,
    output logic [15:0]   open_err_count,
    output logic [15:0]   close_err_count
`endif
);

    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_QUEUE_PAIRS);
    localparam logic [23:0]   QPN_BASE = 24'd256;

    typedef enum logic [2:0] {
        IDLE,
        OPEN_POP,
        OPEN_RSP,
        CLOSE_CHECK,
        CLOSE_PUSH,
        CLOSE_RSP
    } state_t;

    state_t                     state_q;
    logic [MAX_QUEUE_PAIRS-1:0] bitmap_q;
    logic [CW-1:0]              count_q;
    logic [23:0]                open_qpn_q;
    logic                       open_err_q;
    logic [23:0]                close_qpn_q;
    logic                       close_err_q;

    logic [23:0]                pop_off_d;
    logic [23:0]                close_off_d;
    logic [MAX_QUEUE_PAIRS-1:0] pop_mask_d;
    logic [MAX_QUEUE_PAIRS-1:0] close_mask_d;
    logic                       close_ok_d;

    // Offsets are compared at full width so an out-of-range QPN never aliases onto a bitmap bit.
    always_comb begin
        pop_off_d    = s_free_qpn - QPN_BASE;
        close_off_d  = close_qpn_q - QPN_BASE;
        pop_mask_d   = '0;
        close_mask_d = '0;
        for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
            pop_mask_d[i]   = (pop_off_d == 24'(i));
            close_mask_d[i] = (close_off_d == 24'(i));
        end
        close_ok_d = (close_qpn_q >= QPN_BASE) && (|(close_mask_d & bitmap_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bitmap_q    <= '0;
            count_q     <= '0;
            open_qpn_q  <= '0;
            open_err_q  <= 1'b0;
            close_qpn_q <= '0;
            close_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_close_req_valid) begin
                        close_qpn_q <= s_close_req_qpn;
                        state_q     <= CLOSE_CHECK;
                    end else if (s_open_req_valid) begin
                        if (count_q == MAX_CNT) begin
                            open_qpn_q <= '0;
                            open_err_q <= 1'b1;
                            state_q    <= OPEN_RSP;
                        end else begin
                            state_q <= OPEN_POP;
                        end
                    end
                end
                OPEN_POP: begin
                    if (s_free_qpn_valid) begin
                        open_qpn_q <= s_free_qpn;
                        open_err_q <= 1'b0;
                        bitmap_q   <= bitmap_q | pop_mask_d;
                        count_q    <= count_q + CW'(1);
                        state_q    <= OPEN_RSP;
                    end
                end
                OPEN_RSP: begin
                    if (m_open_rsp_ready) state_q <= IDLE;
                end
                CLOSE_CHECK: begin
                    if (close_ok_d) begin
                        state_q <= CLOSE_PUSH;
                    end else begin
                        close_err_q <= 1'b1;
                        state_q     <= CLOSE_RSP;
                    end
                end
                CLOSE_PUSH: begin
                    if (m_free_qpn_ready) begin
                        bitmap_q    <= bitmap_q & ~close_mask_d;
                        count_q     <= count_q - CW'(1);
                        close_err_q <= 1'b0;
                        state_q     <= CLOSE_RSP;
                    end
                end
                CLOSE_RSP: begin
                    if (m_close_rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef QPN_ALLOC_STATS_EN
    logic [15:0] open_err_cnt_q;
    logic [15:0] close_err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_err_cnt_q  <= '0;
            close_err_cnt_q <= '0;
        end else begin
            if (state_q == OPEN_RSP && m_open_rsp_ready && open_err_q && open_err_cnt_q != 16'hFFFF)
                open_err_cnt_q <= open_err_cnt_q + 16'd1;
            if (state_q == CLOSE_RSP && m_close_rsp_ready && close_err_q && close_err_cnt_q != 16'hFFFF)
                close_err_cnt_q <= close_err_cnt_q + 16'd1;
        end
    end

    assign open_err_count  = open_err_cnt_q;
    assign close_err_count = close_err_cnt_q;
`endif

    // Request readies are held low while reset is asserted so nothing is accepted mid-reset.
    assign s_close_req_ready = (state_q == IDLE) && !rst;
    assign s_open_req_ready  = (state_q == IDLE) && !rst && !s_close_req_valid;
    assign s_free_qpn_ready  = (state_q == OPEN_POP);
    assign m_free_qpn_valid  = (state_q == CLOSE_PUSH);
    assign m_free_qpn        = close_qpn_q;
    assign m_open_rsp_valid  = (state_q == OPEN_RSP);
    assign m_open_rsp_qpn    = open_qpn_q;
    assign m_open_rsp_error  = open_err_q;
    assign m_close_rsp_valid = (state_q == CLOSE_RSP);
    assign m_close_rsp_error = close_err_q;
    assign active_qp_count   = count_q;

endmodule
